// File: rtl/text_term_pkg.sv
// Shared constants, FSM state type and byte classification for the text terminal writer.
package text_term_pkg;

    localparam logic [7:0] CHAR_BS       = 8'h08;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_FF       = 8'h0C;
    localparam logic [7:0] CHAR_CR       = 8'h0D;
    localparam logic [7:0] CHAR_BLANK    = 8'h20;
    localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_SCREEN = 2'd1,
        CLR_LINE   = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHAR_PRINT_LO) && (b <= CHAR_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_term_writer_if.sv
// Byte-stream input handshake plus character-RAM write port of the text terminal writer.
interface text_term_writer_if #(
    parameter int ROW_W = 2,
    parameter int COL_W = 5
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;

    modport master (output in_valid, in_data,
                    input  in_ready, wr_en, wr_row, wr_col, wr_data);
    modport slave  (input  in_valid, in_data,
                    output in_ready, wr_en, wr_row, wr_col, wr_data);
endinterface

// File: rtl/text_term_sweep.sv
// Row-major address counter for blanking sweeps; on start it presents the first
// address combinationally so the caller can register a write in the same cycle.
module text_term_sweep #(
    parameter int COLS  = 32,
    parameter int ROWS  = 4,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS),
    parameter int LEN_W = $clog2(COLS * ROWS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROW_W-1:0] start_row,
    input  logic [LEN_W-1:0] len,
    output logic             emit,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             active,
    output logic             done
);
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [LEN_W-1:0] rem_q, rem_d, rem_cur;
    logic             last;

    always_comb begin
        row      = start ? start_row : row_q;
        col      = start ? '0 : col_q;
        rem_cur  = start ? len : rem_q;
        emit     = start || active_q;
        last     = emit && (rem_cur == LEN_W'(1));
        row_d    = row_q;
        col_d    = col_q;
        rem_d    = rem_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (emit) begin
            col_d    = col + COL_W'(1);
            row_d    = (col == COL_W'(COLS - 1)) ? row + ROW_W'(1) : row;
            rem_d    = rem_cur - LEN_W'(1);
            active_d = !last;
            done_d   = last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            done_q   <= done_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rem_q    <= rem_d;
        end
    end

    assign active = active_q;
    assign done   = done_q;

endmodule

// File: rtl/text_term_writer.sv
// Byte-stream to character-RAM terminal writer with cursor, CR/LF/BS/FF handling.
// Define TEXT_TERM_SCROLL_EN to scroll (top_row rotation + bottom-line clear) instead of wrapping.
module text_term_writer
    import text_term_pkg::*;
#(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 4,
    parameter logic [7:0] BLANK = CHAR_BLANK,
    localparam int        COL_W = $clog2(COLS),
    localparam int        ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    text_term_writer_if.slave bus,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] top_row,
    output logic             busy
);
    localparam int LEN_W = $clog2(COLS * ROWS) + 1;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] cur_row_q, cur_row_d, top_row_q, top_row_d, wr_row_q, wr_row_d;
    logic [COL_W-1:0] cur_col_q, cur_col_d, wr_col_q, wr_col_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;

    logic             sw_start, sw_emit, sw_active, sw_done;
    logic [ROW_W-1:0] sw_start_row, sw_row;
    logic [COL_W-1:0] sw_col;
    logic [LEN_W-1:0] sw_len;
    logic             accept, row_adv;

    text_term_sweep #(
        .COLS (COLS), .ROWS (ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .LEN_W(LEN_W)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .start    (sw_start),
        .start_row(sw_start_row),
        .len      (sw_len),
        .emit     (sw_emit),
        .row      (sw_row),
        .col      (sw_col),
        .active   (sw_active),
        .done     (sw_done)
    );

    always_comb begin
        state_d      = state_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        top_row_d    = top_row_q;
        wr_en_d      = 1'b0;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        wr_data_d    = wr_data_q;
        sw_start     = 1'b0;
        sw_start_row = '0;
        sw_len       = LEN_W'(COLS);
        row_adv      = 1'b0;
        accept       = bus.in_valid && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(bus.in_data)) begin
                        wr_en_d   = 1'b1;
                        wr_row_d  = top_row_q + cur_row_q;
                        wr_col_d  = cur_col_q;
                        wr_data_d = bus.in_data;
                        cur_col_d = cur_col_q + COL_W'(1);
                        row_adv   = (cur_col_q == COL_W'(COLS - 1));
                    end else if (bus.in_data == CHAR_CR) begin
                        cur_col_d = '0;
                    end else if (bus.in_data == CHAR_LF) begin
                        cur_col_d = '0;
                        row_adv   = 1'b1;
                    end else if (bus.in_data == CHAR_BS) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - COL_W'(1);
                            wr_en_d   = 1'b1;
                            wr_row_d  = top_row_q + cur_row_q;
                            wr_col_d  = cur_col_q - COL_W'(1);
                            wr_data_d = BLANK;
                        end
                    end else if (bus.in_data == CHAR_FF) begin
                        sw_start = 1'b1;
                        sw_len   = LEN_W'(COLS * ROWS);
                        state_d  = CLR_SCREEN;
                    end
                end
            end
            CLR_SCREEN: begin
                if (sw_done) begin
                    state_d   = IDLE;
                    cur_row_d = '0;
                    cur_col_d = '0;
                    top_row_d = '0;
                end
            end
            CLR_LINE: begin
                // top_row has already rotated, so the new bottom row is the one just above it.
                if (sw_done) begin
                    state_d = IDLE;
                end else if (!sw_active) begin
                    sw_start     = 1'b1;
                    sw_start_row = top_row_q + ROW_W'(ROWS - 1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (row_adv) begin
            if (cur_row_q != ROW_W'(ROWS - 1)) begin
                cur_row_d = cur_row_q + ROW_W'(1);
            end else begin
`ifdef TEXT_TERM_SCROLL_EN
                top_row_d = top_row_q + ROW_W'(1);
                state_d   = CLR_LINE;
`else
                cur_row_d = '0;
`endif
            end
        end

        if (sw_emit) begin
            wr_en_d   = 1'b1;
            wr_row_d  = sw_row;
            wr_col_d  = sw_col;
            wr_data_d = BLANK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            top_row_q <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            top_row_q <= top_row_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_row   = wr_row_q;
    assign bus.wr_col   = wr_col_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state_q != IDLE);
    assign cur_row      = cur_row_q;
    assign cur_col      = cur_col_q;
    assign top_row      = top_row_q;

endmodule

// File: doc/text_term_writer.md
# text_term_writer

Parametrised UART-to-text-buffer terminal writer: consumes received bytes over a valid/ready handshake, tracks a cursor over a COLS×ROWS character grid, and issues single-cycle writes to the write port of the display character RAM read by the VGA text generator. It handles CR, LF, backspace, form-feed clear-screen and optional hardware scrolling. Cursor position is exported for the seven-segment debug display.

## Interface
- COLS, default 32, columns per row; power of two, ≥2
- ROWS, default 4, rows; power of two, ≥2
- BLANK, default 8'h20, byte written by clear and erase operations
- COL_W / ROW_W, derived, $clog2(COLS) / $clog2(ROWS)

- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  received byte available
- in_data  in  8  received byte
- in_ready  out  1  block accepts a byte this cycle
- wr_en  out  1  RAM write strobe, one cycle per write
- wr_row  out  ROW_W  physical RAM row
- wr_col  out  COL_W  RAM column
- wr_data  out  8  RAM write data
- cur_row  out  ROW_W  logical cursor row
- cur_col  out  COL_W  cursor column
- top_row  out  ROW_W  physical row displayed at screen top; reader adds it to its row index
- busy  out  1  clear sweep in progress

## Operation
- Byte accepted when in_valid && in_ready; in_ready = (state == IDLE).
- States: IDLE, CLR_SCREEN, CLR_LINE (scroll builds only).
- Printable 0x20–0x7E: write at (cursor); col+1; from col COLS-1, col→0 and row advance.
- CR 0x0D: col→0, no write. LF 0x0A: col→0 and row advance, no write.
- BS 0x08: col>0 → col-1 and write BLANK at new col; col 0 → no-op.
- FF 0x0C: enter CLR_SCREEN; write BLANK to all ROWS×COLS cells, row-major from physical (0,0); then cursor (0,0), top_row 0, IDLE.
- All other bytes (other controls, ≥0x7F): accepted, ignored.
- Row advance: row<ROWS-1 → row+1; at ROWS-1, behaviour per Configuration.
- wr_row = (top_row + logical row) mod ROWS; widths wrap naturally.

## Timing
- Reset: wr_en 0, wr_row/wr_col/wr_data 0, cur_row/cur_col 0, top_row 0, busy 0, state IDLE (in_ready 1). Reset mid-sweep abandons it.
- Accept at cycle N: character/erase write on wr_* at N+1 using pre-update cursor (BS: post-decrement col); cur_* updated at N+1.
- Sustained one byte per cycle in IDLE.
- FF at N: busy and !in_ready N+1..N+ROWS×COLS; writes every cycle N+1..N+ROWS×COLS; in_ready high N+ROWS×COLS+1.
- Scroll at N: any character write at N+1; line-clear writes N+2..N+COLS+1; in_ready low N+1..N+COLS+1; busy high over clear writes.
- in_valid ignored while in_ready low; source must hold byte.

## Configuration
- TEXT_TERM_SCROLL_EN defined: row advance at ROWS-1 keeps cur_row ROWS-1, increments top_row mod ROWS, enters CLR_LINE clearing the new bottom physical row (COLS writes of BLANK).
- Undefined: row advance at ROWS-1 wraps cur_row to 0, no clear, top_row constant 0, CLR_LINE absent.

## Structure
- Package text_term_pkg: CHAR_BS, CHAR_LF, CHAR_FF, CHAR_CR, CHAR_BLANK, printable bounds 0x20/0x7E, state enum.
- One sub-module text_term_sweep: start/len/done address counter producing sweep row/col, shared by CLR_SCREEN and CLR_LINE.

## Test plan
- Reset, send 'A','B' back-to-back (COLS=32,ROWS=4) -> writes (0,0)=0x41, (0,1)=0x42 at N+1/N+2; cursor (0,2).
- 33 printable bytes from (0,0) -> byte 33 written at (1,0); cursor (1,1).
- 'X', BS, BS -> writes (0,0)=0x58, (0,0)=0x20; second BS no write; cursor (0,0).
- CR then LF from (2,5) -> no writes; cursor (3,0).
- FF from cursor (2,7) -> 128 consecutive BLANK writes, in_ready low 128 cycles; cursor (0,0); assert reset at sweep write 40 -> all outputs zero, in_ready high.
- LF at row 3: scroll build -> top_row 1, 32 BLANK writes to physical row 0, cursor (3,0); non-scroll build -> cursor (0,0), no writes.
